// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
//   NREQ        number of requesters (8)
//   SEL_W       width of a requester index (3)
//   sel_t       requester index type
//   arb_state_t output-stage occupancy (ST_EMPTY / ST_FULL)
//   next_ptr()  modulo-8 increment of a requester index
package mux8_arb_pkg;

   localparam int unsigned NREQ  = 8;
   localparam int unsigned SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } arb_state_t;

   // 3-bit arithmetic gives the 7 -> 0 wrap for free.
   function automatic sel_t next_ptr(input sel_t p);
      return p + sel_t'(1);
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between 8 requesters, the arbiter and the downstream consumer.
// Optional feature macro: MUX8_ARB_LOCK_EN adds the per-lane req_lock signal.
//   req_valid/req_data/req_ready  requester side, lane i = req_data[i*DW +: DW]
//   req_lock                      per-lane burst lock request (MUX8_ARB_LOCK_EN only)
//   out_valid/out_data/out_sel    registered output beat and its source lane
//   out_ready                     downstream accept
// Modports: slave = arbiter side, master = requesters + consumer side.
interface mux8_rr_arbiter_if #(
   parameter int unsigned DW = 1
);

   logic [7:0]      req_valid;
   logic [8*DW-1:0] req_data;
   logic [7:0]      req_ready;
`ifdef MUX8_ARB_LOCK_EN
   logic [7:0]      req_lock;
`endif
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [2:0]      out_sel;
   logic            out_ready;

`ifdef MUX8_ARB_LOCK_EN
   modport slave (
      input  req_valid, req_data, req_lock, out_ready,
      output req_ready, out_valid, out_data, out_sel
   );

   modport master (
      output req_valid, req_data, req_lock, out_ready,
      input  req_ready, out_valid, out_data, out_sel
   );
`else
   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_sel
   );

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_sel
   );
`endif

endinterface

// File: rtl/mux8_rr_pick.sv
// Combinational rotate-priority picker.
//   i_req    request vector, one bit per lane
//   i_ptr    highest-priority lane this cycle
//   o_any    at least one request present
//   o_grant  first requesting lane in order i_ptr, i_ptr+1, .. i_ptr+7 (mod 8)
module mux8_rr_pick
   import mux8_arb_pkg::*;
(
   input  logic [NREQ-1:0] i_req,
   input  sel_t            i_ptr,
   output logic            o_any,
   output sel_t            o_grant
);

   logic w_found;
   sel_t w_idx;

   always_comb begin
      o_any   = |i_req;
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = i_ptr + sel_t'(k);
         if (!w_found && i_req[w_idx]) begin
            o_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving an 8:1 select path into a one-entry output register.
// Optional feature macro: MUX8_ARB_LOCK_EN enables burst locking (req_lock, MAX_BURST).
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    mux8_rr_arbiter_if.slave: req_valid/req_data/req_ready[/req_lock],
//          out_valid/out_data/out_sel/out_ready
// Parameters:
//   DW         data width per lane
//   MAX_BURST  max consecutive beats under lock, >= 1 (MUX8_ARB_LOCK_EN only)
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int unsigned DW = 1
`ifdef MUX8_ARB_LOCK_EN
   ,
   parameter int unsigned MAX_BURST = 4
`endif
) (
   input logic                    clk,
   input logic                    rst_n,
   mux8_rr_arbiter_if.slave       bus
);

   arb_state_t    r_state, w_state_d;
   sel_t          r_ptr, w_ptr_d;
   sel_t          r_sel;
   logic [DW-1:0] r_data;

   logic [NREQ-1:0] w_elig;
   logic            w_any;
   sel_t            w_grant;
   logic            w_can_load;
   logic            w_accept;
   logic [DW-1:0]   w_lane_data;

   assign w_can_load = (r_state == ST_EMPTY) || bus.out_ready;
   // Reset gates the accept so req_ready is held low while rst_n is asserted.
   assign w_accept   = rst_n && w_can_load && w_any;

   mux8_rr_pick u_pick (
      .i_req   (w_elig),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_grant (w_grant)
   );

   assign w_lane_data = bus.req_data[int'(w_grant)*DW +: DW];

   always_comb begin
      bus.req_ready = '0;
      if (w_accept) begin
         bus.req_ready[w_grant] = 1'b1;
      end
   end

`ifdef MUX8_ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   logic             r_lock_act, w_lock_act_d;
   sel_t             r_lock_own, w_lock_own_d;
   logic [CNT_W-1:0] r_burst_cnt, w_cnt_d, w_cnt_inc;

   // While locked only the owner may be granted.
   assign w_elig = r_lock_act ? (bus.req_valid & (NREQ'(1) << r_lock_own)) : bus.req_valid;

   always_comb begin
      w_lock_act_d = r_lock_act;
      w_lock_own_d = r_lock_own;
      w_cnt_d      = r_burst_cnt;
      w_cnt_inc    = r_burst_cnt + CNT_W'(1);
      w_ptr_d      = r_ptr;
      if (w_accept) begin
         if (bus.req_lock[w_grant] && (w_cnt_inc < CNT_W'(MAX_BURST))) begin
            // Keep the pointer parked so the owner stays first after release.
            w_lock_act_d = 1'b1;
            w_lock_own_d = w_grant;
            w_cnt_d      = w_cnt_inc;
         end else begin
            // Unlocked beat, lock dropped, or final beat of a full burst.
            w_lock_act_d = 1'b0;
            w_cnt_d      = '0;
            w_ptr_d      = next_ptr(w_grant);
         end
      end else if (r_lock_act && w_can_load && !bus.req_valid[r_lock_own]) begin
         w_lock_act_d = 1'b0;
         w_cnt_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lock_act  <= 1'b0;
         r_lock_own  <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_lock_act  <= w_lock_act_d;
         r_lock_own  <= w_lock_own_d;
         r_burst_cnt <= w_cnt_d;
      end
   end
`else
   assign w_elig = bus.req_valid;

   always_comb begin
      w_ptr_d = r_ptr;
      if (w_accept) begin
         w_ptr_d = next_ptr(w_grant);
      end
   end
`endif

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_accept) w_state_d = ST_FULL;
         ST_FULL:  if (bus.out_ready && !w_accept) w_state_d = ST_EMPTY;
         default:  w_state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_d;
         r_ptr   <= w_ptr_d;
         if (w_accept) begin
            r_sel  <= w_grant;
            r_data <= w_lane_data;
         end
      end
   end

   assign bus.out_valid = (r_state == ST_FULL);
   assign bus.out_data  = r_data;
   assign bus.out_sel   = r_sel;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed, table-driven bench for mux8_rr_arbiter (DW=1).
// Each row drives inputs for one cycle and checks req_ready plus the registered output
// state present at the start of that cycle. With MUX8_ARB_LOCK_EN, MAX_BURST=4 is used.
module tb_mux8_rr_arbiter;

   typedef struct {
      logic [7:0] valid;
      logic [7:0] lock;
      logic       ordy;
      logic [7:0] exp_rdy;
      logic       exp_ov;
      logic [2:0] exp_sel;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [7:0] lane_data;

   mux8_rr_arbiter_if #(.DW(1)) bus ();

`ifdef MUX8_ARB_LOCK_EN
   mux8_rr_arbiter #(.DW(1), .MAX_BURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`else
   mux8_rr_arbiter #(.DW(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] valid, input logic [7:0] lock,
                               input logic ordy, input logic [7:0] exp_rdy,
                               input logic exp_ov, input logic [2:0] exp_sel);
      vec_t v;
      v.valid   = valid;
      v.lock    = lock;
      v.ordy    = ordy;
      v.exp_rdy = exp_rdy;
      v.exp_ov  = exp_ov;
      v.exp_sel = exp_sel;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] valid, input logic [7:0] lock, input logic ordy);
      bus.req_valid = valid;
      bus.out_ready = ordy;
`ifdef MUX8_ARB_LOCK_EN
      bus.req_lock  = lock;
`else
      if (lock != 8'h00) $display("note: lock vector ignored in this build");
`endif
   endtask

   // Apply one row, check, then advance one clock.
   task automatic apply(input string tag, input int idx, input vec_t v);
      drive(v.valid, v.lock, v.ordy);
      #1;
      chk($sformatf("%s[%0d] req_ready", tag, idx), 32'(bus.req_ready), 32'(v.exp_rdy));
      chk($sformatf("%s[%0d] out_valid", tag, idx), 32'(bus.out_valid), 32'(v.exp_ov));
      if (v.exp_ov) begin
         chk($sformatf("%s[%0d] out_sel", tag, idx), 32'(bus.out_sel), 32'(v.exp_sel));
         chk($sformatf("%s[%0d] out_data", tag, idx), 32'(bus.out_data),
             32'(lane_data[v.exp_sel]));
      end
      @(posedge clk);
      #1;
   endtask

   // Hold reset for ncyc edges with all lanes requesting and downstream stalled.
   task automatic do_reset(input string tag, input int ncyc);
      rst_n = 1'b0;
      drive(8'hFF, 8'hFF, 1'b0);
      for (int n = 0; n < ncyc; n++) begin
         #1;
         chk($sformatf("%s req_ready in reset", tag), 32'(bus.req_ready), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'h0);
         chk($sformatf("%s out_sel", tag), 32'(bus.out_sel), 32'h0);
         chk($sformatf("%s out_data", tag), 32'(bus.out_data), 32'h0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t rr_tbl[$];
      vec_t post_tbl[$];
      n_cmp = 0;
      n_err = 0;
      lane_data = 8'hA5;
      bus.req_data = lane_data;
      rst_n = 1'b0;
      drive(8'hFF, 8'h00, 1'b1);

      // Round-robin sweep and wrap.
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h01, 1'b0, 3'd0));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd0));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h04, 1'b1, 3'd1));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h08, 1'b1, 3'd2));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h10, 1'b1, 3'd3));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h20, 1'b1, 3'd4));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h40, 1'b1, 3'd5));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h80, 1'b1, 3'd6));
      rr_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h01, 1'b1, 3'd7));
      // Backpressure: lane 2 beat held, then lane 5, then lane 2.
      rr_tbl.push_back(mk(8'h24, 8'h00, 1'b1, 8'h04, 1'b1, 3'd0));
      rr_tbl.push_back(mk(8'h24, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2));
      rr_tbl.push_back(mk(8'h24, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2));
      rr_tbl.push_back(mk(8'h24, 8'h00, 1'b1, 8'h20, 1'b1, 3'd2));
      rr_tbl.push_back(mk(8'h24, 8'h00, 1'b1, 8'h04, 1'b1, 3'd5));
      // Sparse skip from ptr=3: lane 7 then wrap to lane 0, then drain to EMPTY.
      rr_tbl.push_back(mk(8'h81, 8'h00, 1'b1, 8'h80, 1'b1, 3'd2));
      rr_tbl.push_back(mk(8'h81, 8'h00, 1'b1, 8'h01, 1'b1, 3'd7));
      rr_tbl.push_back(mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 3'd0));
      rr_tbl.push_back(mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0));
      // Single requester repeats every cycle.
      rr_tbl.push_back(mk(8'h08, 8'h00, 1'b1, 8'h08, 1'b0, 3'd0));
      rr_tbl.push_back(mk(8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3));
      rr_tbl.push_back(mk(8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3));
      // FULL with stalled downstream holds, then new request once drained.
      rr_tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3));
      rr_tbl.push_back(mk(8'h10, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3));
      rr_tbl.push_back(mk(8'h10, 8'h00, 1'b1, 8'h10, 1'b1, 3'd3));
      rr_tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 3'd4));

      // After a mid-operation reset the pointer restarts at lane 0.
      post_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h01, 1'b0, 3'd0));
      post_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd0));

      do_reset("reset", 2);
      for (int i = 0; i < rr_tbl.size(); i++) apply("rr", i, rr_tbl[i]);
      do_reset("reset_mid", 1);
      for (int i = 0; i < post_tbl.size(); i++) apply("post", i, post_tbl[i]);

`ifdef MUX8_ARB_LOCK_EN
      begin
         vec_t lk_tbl[$];
         vec_t rel_tbl[$];
         // Full burst: lane 0, then 4 beats from lane 1, then lanes 2 and 3.
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h01, 1'b0, 3'd0));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h02, 1'b1, 3'd0));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h04, 1'b1, 3'd1));
         lk_tbl.push_back(mk(8'hFF, 8'h02, 1'b1, 8'h08, 1'b1, 3'd2));
         // Lane 4 takes a lock, then the output stalls with the lock held.
         lk_tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd3));
         lk_tbl.push_back(mk(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd4));

         // After reset: no lock owner, ptr 0; then a lock dropped after one beat.
         rel_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h01, 1'b0, 3'd0));
         rel_tbl.push_back(mk(8'h02, 8'h02, 1'b1, 8'h02, 1'b1, 3'd0));
         rel_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 3'd1));
         rel_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h04, 1'b1, 3'd1));
         rel_tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h08, 1'b1, 3'd2));

         do_reset("lock_reset", 1);
         for (int i = 0; i < lk_tbl.size(); i++) apply("lock", i, lk_tbl[i]);
         do_reset("lock_reset_mid", 1);
         for (int i = 0; i < rel_tbl.size(); i++) apply("lock_rel", i, rel_tbl[i]);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
